// File: rtl/cordic_ln_iter_ctrl.sv
// Control FSM for the hyperbolic-CORDIC ln datapath: operand load, N_ITER
// micro-rotations (indices 4 and 13 repeated), then result capture.
module cordic_ln_iter_ctrl #(
    parameter int N_ITER = 24,
    parameter int IW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beg_fsm,
    input  logic          ack_fsm,
    input  logic          y_sign,
    output logic          ready,
    output logic          sel_init,
    output logic          enab_reg,
    output logic [IW-1:0] iter_idx,
    output logic          op_sub,
    output logic          enab_d_out,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IW-1:0] LAST_STEP = IW'(N_ITER - 1);
    localparam logic [IW-1:0] REP_A     = IW'(4);
    localparam logic [IW-1:0] REP_B     = IW'(13);

    state_t        state_q, state_d;
    logic [IW-1:0] step_q, step_d;
    logic          rep4_q, rep4_d;
    logic          rep13_q, rep13_d;
    logic [IW-1:0] iter_idx_q, iter_idx_d;
    logic          ready_q, ready_d;
    logic          sel_init_q, sel_init_d;
    logic          enab_reg_q, enab_reg_d;
    logic          enab_d_out_q, enab_d_out_d;
    logic          done_q, done_d;

    // Registered outputs are computed for the state being entered, so each
    // output is valid for the whole cycle that state occupies.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        rep4_d       = rep4_q;
        rep13_d      = rep13_q;
        iter_idx_d   = iter_idx_q;
        ready_d      = 1'b0;
        sel_init_d   = 1'b0;
        enab_reg_d   = 1'b0;
        enab_d_out_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (beg_fsm) begin
                    state_d    = S_LOAD;
                    sel_init_d = 1'b1;
                    enab_reg_d = 1'b1;
                    iter_idx_d = IW'(1);
                end else begin
                    ready_d    = 1'b1;
                    iter_idx_d = '0;
                end
            end
            S_LOAD: begin
                state_d    = S_ITER;
                enab_reg_d = 1'b1;
                step_d     = '0;
                rep4_d     = 1'b0;
                rep13_d    = 1'b0;
            end
            S_ITER: begin
                step_d = step_q + IW'(1);
                if (step_q == LAST_STEP) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    enab_d_out_d = 1'b1;
                end else begin
                    enab_reg_d = 1'b1;
                    // Hyperbolic convergence needs indices 4 and 13 executed twice.
                    if (iter_idx_q == REP_A && !rep4_q) begin
                        rep4_d = 1'b1;
                    end else if (iter_idx_q == REP_B && !rep13_q) begin
                        rep13_d = 1'b1;
                    end else begin
                        iter_idx_d = iter_idx_q + IW'(1);
                    end
                end
            end
            S_DONE: begin
                if (ack_fsm) begin
                    state_d    = S_IDLE;
                    ready_d    = 1'b1;
                    iter_idx_d = '0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            rep4_q       <= 1'b0;
            rep13_q      <= 1'b0;
            iter_idx_q   <= '0;
            ready_q      <= 1'b1;
            sel_init_q   <= 1'b0;
            enab_reg_q   <= 1'b0;
            enab_d_out_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            rep4_q       <= rep4_d;
            rep13_q      <= rep13_d;
            iter_idx_q   <= iter_idx_d;
            ready_q      <= ready_d;
            sel_init_q   <= sel_init_d;
            enab_reg_q   <= enab_reg_d;
            enab_d_out_q <= enab_d_out_d;
            done_q       <= done_d;
        end
    end

    assign ready      = ready_q;
    assign sel_init   = sel_init_q;
    assign enab_reg   = enab_reg_q;
    assign iter_idx   = iter_idx_q;
    assign enab_d_out = enab_d_out_q;
    assign done       = done_q;
    // Direction follows the live Y sign, so it stays combinational.
    assign op_sub     = (state_q == S_ITER) & ~y_sign;

endmodule

// File: doc/cordic_ln_iter_ctrl.md
Name: cordic_ln_iter_ctrl

Overview:
- Control FSM for the hyperbolic-CORDIC natural-logarithm datapath.
- Sequences one ln operation: initial operand load, N_ITER micro-rotations (hyperbolic repeats at indices 4 and 13), then result capture.
- Drives the operand-select inputs (MS) of the datapath's 2:1 operand multiplexers, the X/Y/Z register enables, the iteration index for the shifter/LUT, and the add/sub direction.
- Handshakes with the top-level FPU controller through beg_fsm/ack_fsm.

Parameters:
- N_ITER, 24, total rotation steps including repeats; 24 gives indices 1..22 plus repeats of 4 and 13.
- IW, 5, width of the iteration index and step counter; must satisfy 2^IW > N_ITER.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-low reset.
- beg_fsm  input  1  start request, sampled in IDLE only.
- ack_fsm  input  1  result acknowledge, sampled in DONE only.
- y_sign  input  1  sign bit of the current Y register (1 = negative).
- ready  output  1  high in IDLE; block can accept beg_fsm.
- sel_init  output  1  MS for the operand muxes: 1 selects the initial operand (D_1), 0 selects the feedback path (D_0).
- enab_reg  output  1  load enable for the X/Y/Z iteration registers.
- iter_idx  output  IW  current CORDIC shift/LUT index.
- op_sub  output  1  MS for the add/sub muxes: 1 = X/Y subtract direction (d = -1).
- enab_d_out  output  1  one-cycle load pulse for the output result register.
- done  output  1  result valid, held until acknowledged.

Behaviour:
- All state is updated on the rising clk edge. rst=0 at an edge forces IDLE on that edge, regardless of state (reset mid-operation aborts it).
- Reset values: ready=1; sel_init=0; enab_reg=0; iter_idx=0; op_sub=0; enab_d_out=0; done=0. Step counter=0. Repeat flags rep4=0, rep13=0.
- All outputs are registered except op_sub.
- States: IDLE, LOAD, ITER, DONE.
- IDLE: ready=1, all other outputs 0.
  - beg_fsm=1 -> LOAD.
- LOAD (exactly 1 cycle): ready=0, sel_init=1, enab_reg=1, iter_idx=1.
  - Clears the step counter and both repeat flags.
  - -> ITER.
- ITER (exactly N_ITER cycles): sel_init=0, enab_reg=1.
  - op_sub = ~y_sign, combinational, valid only in ITER; forced to 0 elsewhere.
  - Index update per cycle:
    - if iter_idx==4 and rep4==0: set rep4, hold index.
    - else if iter_idx==13 and rep13==0: set rep13, hold index.
    - else iter_idx+1.
  - The step counter increments every ITER cycle.
  - When the step counter == N_ITER-1: -> DONE, with enab_reg deasserted on the next cycle.
- Index sequence (N_ITER=24): 1,2,3,4,4,5,...,13,13,14,...,22.
- DONE: enab_reg=0; iter_idx holds its last value.
  - enab_d_out=1 only in the first DONE cycle.
  - done=1 from the first DONE cycle until exit.
  - ack_fsm=1 -> IDLE: done drops and ready rises on the same edge.
- Latency: beg_fsm sampled at edge E0 -> LOAD in cycle 1 -> ITER in cycles 2..N_ITER+1 -> first DONE cycle at N_ITER+2 (cycle 26 for the default).
- Boundary conditions:
  - beg_fsm outside IDLE: ignored, not queued.
  - ack_fsm outside DONE: ignored.
  - beg_fsm and ack_fsm both high in DONE: ack wins -> IDLE; beg is not captured and must be held or re-asserted in IDLE.
  - beg_fsm held high continuously: a new operation starts on the first IDLE cycle (back-to-back operations with one IDLE cycle between).
  - iter_idx never wraps for legal N_ITER.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> ready=1, every other output 0, iter_idx=0, and outputs stay stable with beg_fsm=0.
- Single operation, N_ITER=24: pulse beg_fsm for 1 cycle -> LOAD cycle with sel_init=1 and enab_reg=1; then 24 enab_reg cycles with sel_init=0 and iter_idx exactly 1,2,3,4,4,5..13,13,14..22; enab_d_out is a single pulse at cycle 26; done=1 until ack.
- Direction tracking: toggle y_sign every ITER cycle -> op_sub equals ~y_sign in the same cycle; op_sub=0 in IDLE, LOAD and DONE.
- Handshake corners: beg_fsm pulsed during ITER -> no restart and done timing unchanged. ack_fsm during ITER -> ignored. beg_fsm and ack_fsm together in DONE -> IDLE with ready=1 and no new LOAD.
- Reset mid-operation: rst=0 at step 10 -> IDLE next edge, all outputs back to reset values. A following beg_fsm -> sequence restarts at iter_idx=1 with the repeat flags cleared (index 4 repeated again).
- Back-to-back: beg_fsm held high and ack_fsm pulsed in the first DONE cycle -> second LOAD occurs two cycles after the ack edge; the second index sequence is identical to the first.
